// File: rtl/led_s2p_rx.sv
// Serial-to-parallel receiver for the 4-wire LED shift-register link, with a valid/ready output.
// Define LED_RX_SYNC_EN to put a 2-flop synchronizer ahead of the input register (async sources).
module led_s2p_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_clk,
  input  logic             led_clr,
  input  logic             led_do,
  input  logic             led_en,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             frame_err,
  output logic             overrun
);

  // Pin vector order is {clr, en, clk, do}; clr resets high so reset never looks like a clear edge.
  localparam logic [3:0] PIN_RST = 4'b1000;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [3:0] pin_raw;
  logic [3:0] in_d, in_q;
  logic [3:0] prev_d, prev_q;

  assign pin_raw = {led_clr, led_en, led_clk, led_do};

`ifdef LED_RX_SYNC_EN
  logic [3:0] meta_d, meta_q;
  logic [3:0] sync_d, sync_q;

  always_comb begin
    meta_d = pin_raw;
    sync_d = meta_q;
    in_d   = sync_q;
    prev_d = in_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= PIN_RST;
      sync_q <= PIN_RST;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end
`else
  always_comb begin
    in_d   = pin_raw;
    prev_d = in_q;
  end
`endif

  logic clr_n, clk_rise, en_rise, en_fall;

  assign clr_n    = in_q[3];
  assign en_rise  =  in_q[2] & ~prev_q[2];
  assign en_fall  = ~in_q[2] &  prev_q[2];
  assign clk_rise =  in_q[1] & ~prev_q[1];

  state_t           state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q, shreg_v;
  logic [CW-1:0]    cnt_d, cnt_q, cnt_v;
  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic             frame_err_d, frame_err_q;
  logic             overrun_d, overrun_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    shreg_v     = shreg_q;
    cnt_v       = cnt_q;

    if (valid_q && ready) valid_d = 1'b0;

    if (!clr_n) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_rise) begin
            state_d = SHIFT;
            shreg_d = '0;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          // A bit arriving with the frame end is shifted before the length check.
          if (clk_rise) begin
            shreg_v = {shreg_q[WIDTH-2:0], in_q[0]};
            if (cnt_q < CW'(WIDTH + 1)) cnt_v = cnt_q + CW'(1);
          end
          shreg_d = shreg_v;
          cnt_d   = cnt_v;
          if (en_fall) begin
            state_d = IDLE;
            if (cnt_v == CW'(WIDTH)) begin
              data_d    = shreg_v;
              valid_d   = 1'b1;
              overrun_d = valid_q && !ready;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q        <= PIN_RST;
      prev_q      <= PIN_RST;
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      in_q        <= in_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_led_s2p_rx.sv
// Self-checking bench for led_s2p_rx: frames, length errors, overrun, clear, reset and latency.
module tb_led_s2p_rx;

  localparam int WIDTH = 16;
`ifdef LED_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst, led_clk, led_clr, led_do, led_en, ready;
  logic [WIDTH-1:0] data;
  logic             valid, frame_err, overrun;

  int tests_run = 0;
  int fails     = 0;
  int err_cnt   = 0;
  int ovr_cnt   = 0;
  logic [WIDTH-1:0] exp_q[$];

  led_s2p_rx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .led_clk(led_clk), .led_clr(led_clr), .led_do(led_do),
    .led_en(led_en), .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [31:0] word, input int nbits);
    led_en = 1'b1;
    tick(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      led_do = word[i];
      tick(4);
      led_clk = 1'b1;
      tick(4);
      led_clk = 1'b0;
    end
    tick(4);
  endtask

  // Ends the frame and returns cycles until valid is seen (bounded).
  task automatic end_and_wait_valid(output int lat);
    led_en = 1'b0;
    lat = 0;
    while (!valid && lat < 50) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic check_pop(input string name);
    logic [WIDTH-1:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, data=%h", name, data);
    end else begin
      e = exp_q.pop_front();
      if (data !== e) begin
        fails++;
        $display("FAIL %s: data=%h expected %h", name, data, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; led_clk = 1'b0; led_clr = 1'b1; led_do = 1'b0; led_en = 1'b0; ready = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(4);
    tests_run++;
    if ({data, valid, frame_err, overrun} !== {16'h0, 3'b000}) begin
      fails++;
      $display("FAIL reset: data=%h valid=%b err=%b ovr=%b expected all 0", data, valid, frame_err, overrun);
    end
  endtask

  task automatic test_good_frame();
    int lat, e0;
    e0 = err_cnt;
    ready = 1'b1;
    exp_q.push_back(16'hA5C3);
    send_bits(32'hA5C3, 16);
    end_and_wait_valid(lat);
    tests_run++;
    if (lat !== LAT + 1) begin
      fails++;
      $display("FAIL latency_ready1: cycles=%0d expected %0d", lat - 1, LAT);
    end
    check_pop("good_frame");
    tick(1);
    tests_run++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_one_cycle: valid=%b expected 0", valid);
    end
    tick(4);
    tests_run++;
    if (err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL good_no_err: frame_err pulses=%0d expected 0", err_cnt - e0);
    end
  endtask

  task automatic test_frame_err();
    int nb[2] = '{15, 17};
    foreach (nb[k]) begin
      int e0;
      e0 = err_cnt;
      send_bits(32'h1FFFF, nb[k]);
      led_en = 1'b0;
      tick(8);
      tests_run++;
      if (err_cnt - e0 !== 1) begin
        fails++;
        $display("FAIL frame_err_%0d: pulses=%0d expected 1", nb[k], err_cnt - e0);
      end
      tests_run++;
      if (valid !== 1'b0 || data !== 16'hA5C3) begin
        fails++;
        $display("FAIL frame_err_hold_%0d: valid=%b data=%h expected 0 a5c3", nb[k], valid, data);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, o0;
    o0 = ovr_cnt;
    ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_bits(32'h1234, 16);
    end_and_wait_valid(lat);
    tests_run++;
    if (lat !== LAT + 1) begin
      fails++;
      $display("FAIL latency_ready0: cycles=%0d expected %0d", lat - 1, LAT);
    end
    tick(6);
    check_pop("first_1234");
    exp_q.push_back(16'hBEEF);
    send_bits(32'hBEEF, 16);
    led_en = 1'b0;
    tick(8);
    check_pop("second_beef");
    tests_run++;
    if (valid !== 1'b1 || ovr_cnt - o0 !== 1) begin
      fails++;
      $display("FAIL overrun: valid=%b pulses=%0d expected 1 1", valid, ovr_cnt - o0);
    end
    ready = 1'b1;
    tick(1);
    tests_run++;
    if (valid !== 1'b0) begin
      fails++;
      $display("FAIL consume: valid=%b expected 0", valid);
    end
  endtask

  task automatic test_clear();
    int e0;
    e0 = err_cnt;
    send_bits(32'h00AB, 8);
    led_clr = 1'b0;
    tick(6);
    led_en = 1'b0;
    tick(4);
    led_clr = 1'b1;
    tick(6);
    tests_run++;
    if (data !== 16'h0 || valid !== 1'b0 || err_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL clear: data=%h valid=%b err=%0d expected 0 0 0", data, valid, err_cnt - e0);
    end
    exp_q.push_back(16'h00FF);
    send_bits(32'h00FF, 16);
    led_en = 1'b0;
    tick(8);
    check_pop("after_clear");
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    send_bits(32'h001F, 5);
    rst = 1'b1;
    tick(1);
    tests_run++;
    if ({data, valid, frame_err, overrun} !== {16'h0, 3'b000}) begin
      fails++;
      $display("FAIL reset_mid: data=%h valid=%b err=%b ovr=%b expected all 0", data, valid, frame_err, overrun);
    end
    led_en = 1'b0;
    led_clk = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
    exp_q.push_back(16'h8001);
    send_bits(32'h8001, 16);
    end_and_wait_valid(lat);
    check_pop("after_reset");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_frame_err();
    test_back_to_back();
    test_clear();
    test_reset_mid_frame();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
